multicycle_core: RTL and testbench
==================================

Name: multicycle_core

Overview:
Parametrised multi-cycle successor of the single-cycle LEGv8 CPU top. A state machine sequences fetch, decode, execute, memory and writeback over several clocks. One unified memory port with a req/ready handshake serves both instructions and data, so memory latency is variable.

Parameters:
XLEN, 64, datapath, register and address width in bits (legal values: 32, 64)
RESET_PC, 0, byte address loaded into PC on reset
NREGS, 32, architectural registers; register NREGS-1 is XZR (reads 0, writes dropped)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
mem_req  output  1  memory transaction request
mem_we  output  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  output  XLEN  byte address
mem_wdata  output  XLEN  store data
mem_rdata  input  XLEN  read data; instruction is in bits [31:0]
mem_ready  input  1  transaction completes on a clk edge where mem_req=1 and mem_ready=1
halted  output  1  sticky flag: illegal opcode seen
pc_out  output  XLEN  current PC, for debug

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=FETCH, PC=RESET_PC.
  - All registers cleared to 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
  - Deassertion is synchronised internally; the first fetch request appears on the first clk edge after deassertion.
- Handshake:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - mem_req drops the cycle after completion unless the next state issues a new request.
  - mem_ready is ignored while mem_req=0.
- States:
  - FETCH: request a read at PC. On completion, latch IR, set IPC=PC, set PC=PC+4 (wraps mod 2^XLEN).
  - DECODE: read Rn=IR[9:5]. Rm=IR[20:16] for R-format; Rt=IR[4:0] for STUR/CBZ. Compute sign-extended immediates.
  - EXEC:
    - ALU op.
    - CBZ: if Rt==0, PC=IPC+(sext(IR[23:5])<<2).
    - B: PC=IPC+(sext(IR[25:0])<<2).
    - Branches then go to FETCH.
  - MEM: LDUR or STUR at address Rn+sext(IR[20:12]), held until completion.
  - WB: write Rd=IR[4:0] with the ALU result or the load data.
  - HALT: terminal. halted=1; leave only via reset.
- Opcodes:
  - IR[31:21]: ADD=0x458, SUB=0x658, AND=0x450, ORR=0x550, LDUR=0x7C2, STUR=0x7C0.
  - IR[31:24]=0xB4 is CBZ. IR[31:26]=0x05 is B.
  - Any other encoding goes DECODE->HALT. The register file is unchanged and no memory request is made.
- Latency with zero-wait memory: R-type 4 clk, LDUR 5, STUR 4, CBZ/B 3. Each wait cycle on mem_ready adds 1.
- Arithmetic:
  - Modulo 2^XLEN; no flags.
  - For XLEN=32, addresses and immediates are truncated after sign extension.
- Hazards: none, because instructions never overlap.

Optional Feature:
Macro PERF_COUNTERS_EN.
- Defined:
  - Two XLEN-wide counters, exposed on extra output ports perf_cycles and perf_retired.
  - perf_cycles increments every clk while not halted.
  - perf_retired increments on leaving WB, on a branch EXEC, and on STUR MEM completion.
  - Both reset to 0 and wrap.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package multicycle_pkg holds:
  - State enum: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - Opcode constants: OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ, OP_B.
  - ALU op enum.
- One natural sub-module: multicycle_regfile.
  - Parametrised by XLEN and NREGS.
  - Two combinational read ports, one synchronous write port, XZR hardwired to 0.
  - Asynchronous active-low clear.
- The FSM and datapath stay in the top.

Test Plan:
- Reset with RESET_PC=0x100, memory always ready -> first mem_req=1 with mem_addr=0x100, mem_we=0 on the first edge after release; halted=0.
- X1=5, X2=7, then ADD X3,X1,X2 followed by SUB X4,X2,X1 -> X3=12, X4=2; each instruction takes 4 clk.
- STUR X3,[X0,#8] then LDUR X5,[X0,#8] with X0=0x200; memory inserts 3 wait cycles on every access -> write at 0x208 with data 12; X5=12; address held stable during the waits; LDUR takes 5+6 clk.
- CBZ X6,#+3 at PC 0x40 with X6=0 -> next fetch at 0x4C. Repeat with X6=1 -> next fetch at 0x44.
- Fetch of 0xFFFFFFFF -> halted=1, no further mem_req, registers unchanged. Assert reset_n=0 mid-MEM of a load -> mem_req drops immediately (asynchronously) and PC=RESET_PC.
- With PERF_COUNTERS_EN: run the ADD/SUB program (2 instructions, 8 clk, zero wait) -> perf_retired=2, perf_cycles=8.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and opcode constants for the multi-cycle LEGv8 core.
package multicycle_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_op_t;

  // Instruction class resolved in DECODE; CLS_ILL sends the core to HALT.
  typedef enum logic [2:0] {CLS_ALU, CLS_LDUR, CLS_STUR, CLS_CBZ, CLS_B, CLS_ILL} cls_t;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [5:0]  OP_B    = 6'h05;

endpackage

// File: rtl/multicycle_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// The last register is XZR: it resets to zero and is never written.
module multicycle_regfile
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS - 1; i++)
        if (we && waddr == AW'(i)) regs[i] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle LEGv8 core: FETCH/DECODE/EXEC/MEM/WB over one req/ready memory port.
// Optional macro PERF_COUNTERS_EN adds perf_cycles and perf_retired outputs.
module multicycle_core
  import multicycle_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              NREGS    = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            halted,
  output logic [XLEN-1:0] pc_out
`ifdef PERF_COUNTERS_EN
  ,
  output logic [XLEN-1:0] perf_cycles,
  output logic [XLEN-1:0] perf_retired
`endif
);

  localparam int AW = $clog2(NREGS);

  state_t          state_reg, state_next;
  logic            run_reg;
  logic [XLEN-1:0] pc_reg, ipc_reg, a_reg, b_reg, imm_reg, res_reg;
  logic [31:0]     ir_reg;
  cls_t            cls_reg, cls_dec;
  alu_op_t         op_reg, op_dec;
  logic [63:0]     imm64;
  logic [XLEN-1:0] rdata_a, rdata_b, alu_out;
  logic [AW-1:0]   raddr_b;
  logic            mem_done, rf_we, take_branch;

  always_comb begin
    cls_dec = CLS_ILL;
    op_dec  = ALU_ADD;
    case (ir_reg[31:21])
      OP_ADD:  cls_dec = CLS_ALU;
      OP_SUB:  begin cls_dec = CLS_ALU; op_dec = ALU_SUB; end
      OP_AND:  begin cls_dec = CLS_ALU; op_dec = ALU_AND; end
      OP_ORR:  begin cls_dec = CLS_ALU; op_dec = ALU_ORR; end
      OP_LDUR: cls_dec = CLS_LDUR;
      OP_STUR: cls_dec = CLS_STUR;
      default: begin
        if (ir_reg[31:24] == OP_CBZ)     cls_dec = CLS_CBZ;
        else if (ir_reg[31:26] == OP_B)  cls_dec = CLS_B;
      end
    endcase
  end

  // Immediates are built at 64 bits and truncated to XLEN afterwards.
  always_comb begin
    imm64 = {{55{ir_reg[20]}}, ir_reg[20:12]};
    if (cls_dec == CLS_CBZ)    imm64 = {{43{ir_reg[23]}}, ir_reg[23:5], 2'b00};
    else if (cls_dec == CLS_B) imm64 = {{36{ir_reg[25]}}, ir_reg[25:0], 2'b00};
  end

  assign raddr_b = (cls_dec == CLS_ALU) ? AW'(ir_reg[20:16]) : AW'(ir_reg[4:0]);

  always_comb begin
    alu_out = a_reg + imm_reg;
    if (cls_reg == CLS_ALU) begin
      case (op_reg)
        ALU_ADD: alu_out = a_reg + b_reg;
        ALU_SUB: alu_out = a_reg - b_reg;
        ALU_AND: alu_out = a_reg & b_reg;
        default: alu_out = a_reg | b_reg;
      endcase
    end
  end

  assign take_branch = (state_reg == EXEC) &&
                       (cls_reg == CLS_B || (cls_reg == CLS_CBZ && b_reg == '0));

  // run_reg releases the bus one edge after reset deassertion and drops it asynchronously.
  assign mem_req   = run_reg && (state_reg == FETCH || state_reg == MEM);
  assign mem_we    = mem_req && (state_reg == MEM) && (cls_reg == CLS_STUR);
  assign mem_addr  = !mem_req ? '0 : (state_reg == FETCH) ? pc_reg : res_reg;
  assign mem_wdata = mem_we ? b_reg : '0;
  assign mem_done  = mem_req && mem_ready;
  assign halted    = (state_reg == HALT);
  assign pc_out    = pc_reg;

  always_comb begin
    state_next = state_reg;
    rf_we      = 1'b0;
    case (state_reg)
      FETCH:  if (mem_done) state_next = DECODE;
      DECODE: state_next = (cls_dec == CLS_ILL) ? HALT : EXEC;
      EXEC: begin
        case (cls_reg)
          CLS_ALU:            state_next = WB;
          CLS_LDUR, CLS_STUR: state_next = MEM;
          default:            state_next = FETCH;
        endcase
      end
      MEM:    if (mem_done) state_next = (cls_reg == CLS_LDUR) ? WB : FETCH;
      WB: begin
        rf_we      = 1'b1;
        state_next = FETCH;
      end
      default: state_next = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= FETCH;
      run_reg   <= 1'b0;
      pc_reg    <= RESET_PC;
      ipc_reg   <= '0;
      ir_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      imm_reg   <= '0;
      res_reg   <= '0;
      cls_reg   <= CLS_ILL;
      op_reg    <= ALU_ADD;
    end else begin
      run_reg   <= 1'b1;
      state_reg <= state_next;
      case (state_reg)
        FETCH: if (mem_done) begin
          ir_reg  <= mem_rdata[31:0];
          ipc_reg <= pc_reg;
          pc_reg  <= pc_reg + XLEN'(4);
        end
        DECODE: begin
          a_reg   <= rdata_a;
          b_reg   <= rdata_b;
          imm_reg <= imm64[XLEN-1:0];
          cls_reg <= cls_dec;
          op_reg  <= op_dec;
        end
        EXEC: begin
          res_reg <= alu_out;
          if (take_branch) pc_reg <= ipc_reg + imm_reg;
        end
        MEM: if (mem_done && cls_reg == CLS_LDUR) res_reg <= mem_rdata;
        default: ;
      endcase
    end
  end

  multicycle_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .raddr_a (AW'(ir_reg[9:5])),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (rf_we),
    .waddr   (AW'(ir_reg[4:0])),
    .wdata   (res_reg)
  );

`ifdef PERF_COUNTERS_EN
  logic retire;
  assign retire = (state_reg == WB) || take_branch ||
                  (state_reg == EXEC && cls_reg == CLS_CBZ) ||
                  (state_reg == MEM && mem_done && cls_reg == CLS_STUR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles  <= '0;
      perf_retired <= '0;
    end else begin
      if (run_reg && state_reg != HALT) perf_cycles <= perf_cycles + XLEN'(1);
      if (retire) perf_retired <= perf_retired + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: table of ALU programs plus hand-written
// sequences for wait states, branches, halt and asynchronous reset.
module tb_multicycle_core;

  localparam logic [10:0] E_ADD = 11'h458, E_SUB = 11'h658, E_AND = 11'h450;
  localparam logic [10:0] E_ORR = 11'h550, E_LDUR = 11'h7C2, E_STUR = 11'h7C0;
  localparam logic [31:0] ILLEGAL = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req, mem_we, halted;
  logic [63:0] mem_addr, mem_wdata, pc_out;
  logic [63:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
`ifdef PERF_COUNTERS_EN
  logic [63:0] perf_cycles, perf_retired;
`endif

  multicycle_core #(.XLEN(64), .RESET_PC(64'h100), .NREGS(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .pc_out    (pc_out)
`ifdef PERF_COUNTERS_EN
    ,
    .perf_cycles  (perf_cycles),
    .perf_retired (perf_retired)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Memory model and scoreboard.
  logic [31:0] imem [logic [63:0]];
  logic [63:0] dmem [logic [63:0]];
  typedef struct { logic [63:0] addr; logic [63:0] data; } wr_t;
  wr_t         exp_wq[$];
  logic [63:0] fq_addr[$];
  longint      fq_cyc[$];
  longint      cyc = 0;
  int          wait_n = 0;
  int          wcnt = 0;
  logic [63:0] held_addr, held_wdata;
  logic        held_we;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ready = 1'b1;  // ready while idle must be ignored by the DUT
      wcnt = 0;
    end else begin
      if (wcnt == 0) begin
        held_addr = mem_addr; held_we = mem_we; held_wdata = mem_wdata;
      end else begin
        check("hold_addr", mem_addr, held_addr);
        check("hold_we_wdata", {mem_we, mem_wdata[62:0]}, {held_we, held_wdata[62:0]});
      end
      if (wcnt < wait_n) begin
        mem_ready = 1'b0;
        wcnt++;
      end else begin
        mem_ready = 1'b1;
        wcnt = 0;
        if (mem_we) begin
          wr_t w;
          dmem[mem_addr] = mem_wdata;
          if (exp_wq.size() == 0) begin
            check("unexpected_write_addr", mem_addr, 64'hDEAD);
          end else begin
            w = exp_wq.pop_front();
            check("write_addr", mem_addr, w.addr);
            check("write_data", mem_wdata, w.data);
          end
        end else if (imem.exists(mem_addr)) begin
          mem_rdata = {32'h0, imem[mem_addr]};
          fq_addr.push_back(mem_addr);
          fq_cyc.push_back(cyc + 1);
        end else if (dmem.exists(mem_addr)) begin
          mem_rdata = dmem[mem_addr];
        end else begin
          mem_rdata = '0;
        end
      end
    end
  end

  function automatic logic [31:0] enc_r(logic [10:0] op, int rd, int rn, int rm);
    return {op, 5'(rm), 6'b0, 5'(rn), 5'(rd)};
  endfunction
  function automatic logic [31:0] enc_d(logic [10:0] op, int rt, int rn, int imm);
    return {op, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] enc_cbz(int rt, int off);
    return {8'hB4, 19'(off), 5'(rt)};
  endfunction
  function automatic logic [31:0] enc_b(int off);
    return {6'h05, 26'(off)};
  endfunction
  function automatic logic [63:0] fa(int i);
    return (i < fq_addr.size()) ? fq_addr[i] : 64'hDEAD;
  endfunction
  function automatic logic [63:0] lat(int i);
    return (i + 1 < fq_cyc.size()) ? 64'(fq_cyc[i+1] - fq_cyc[i]) : 64'hDEAD;
  endfunction

  task automatic clear_all();
    imem.delete(); dmem.delete(); exp_wq.delete(); fq_addr.delete(); fq_cyc.delete();
  endtask

  task automatic start_run();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_to_halt(input string name, input int max_cyc);
    int n = 0;
    while (!halted && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {63'h0, halted}, 64'h1);
  endtask

  typedef struct {
    logic [10:0] op; logic [63:0] a; logic [63:0] b; int waits; logic [63:0] exp; int exp_lat;
  } vec_t;
  vec_t vecs [7];

  initial begin
    vecs[0] = '{E_ADD, 64'd5, 64'd7, 0, 64'd12, 4};
    vecs[1] = '{E_SUB, 64'd7, 64'd5, 0, 64'd2, 4};
    vecs[2] = '{E_AND, 64'hF0F0, 64'hFF00, 1, 64'hF000, 5};
    vecs[3] = '{E_ORR, 64'hF0F0, 64'h0F0F, 2, 64'hFFFF, 6};
    vecs[4] = '{E_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd0, 4};
    vecs[5] = '{E_SUB, 64'd0, 64'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4};
    vecs[6] = '{E_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 64'd0, 4};

    // Reset state and first fetch request.
    clear_all();
    imem[64'h100] = ILLEGAL;
    wait_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req", {63'h0, mem_req}, 64'h0);
    check("reset_we", {63'h0, mem_we}, 64'h0);
    check("reset_addr", mem_addr, 64'h0);
    check("reset_wdata", mem_wdata, 64'h0);
    check("reset_halted", {63'h0, halted}, 64'h0);
    check("reset_pc", pc_out, 64'h100);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("first_req", {63'h0, mem_req}, 64'h1);
    check("first_addr", mem_addr, 64'h100);
    check("first_we", {63'h0, mem_we}, 64'h0);
    check("first_halted", {63'h0, halted}, 64'h0);

    // Halt on illegal opcode: no further requests, PC frozen after the fetch.
    run_to_halt("halt_reached", 50);
    begin
      int reqs = 0;
      for (int i = 0; i < 16; i++) begin
        @(posedge clk); #1;
        if (mem_req) reqs++;
      end
      check("halt_no_req", 64'(reqs), 64'h0);
    end
    check("halt_pc", pc_out, 64'h104);
    check("halt_fetches", 64'(fq_addr.size()), 64'h1);

    // Table-driven ALU programs: load two operands, operate, store, halt.
    foreach (vecs[v]) begin
      clear_all();
      wait_n = vecs[v].waits;
      dmem[64'h80] = vecs[v].a;
      dmem[64'h88] = vecs[v].b;
      imem[64'h100] = enc_d(E_LDUR, 1, 31, 'h80);
      imem[64'h104] = enc_d(E_LDUR, 2, 31, 'h88);
      imem[64'h108] = enc_r(vecs[v].op, 3, 1, 2);
      imem[64'h10C] = enc_d(E_STUR, 3, 31, 'h90);
      imem[64'h110] = ILLEGAL;
      exp_wq.push_back('{64'h90, vecs[v].exp});
      start_run();
      run_to_halt($sformatf("vec%0d_halt", v), 400);
      check($sformatf("vec%0d_writes_left", v), 64'(exp_wq.size()), 64'h0);
      check($sformatf("vec%0d_lat", v), lat(2), 64'(vecs[v].exp_lat));
      check($sformatf("vec%0d_pc", v), pc_out, 64'h114);
    end

    // STUR then LDUR through X0 with three wait cycles on every access.
    clear_all();
    wait_n = 3;
    dmem[64'h80] = 64'h200;
    dmem[64'h88] = 64'd12;
    imem[64'h100] = enc_d(E_LDUR, 0, 31, 'h80);
    imem[64'h104] = enc_d(E_LDUR, 3, 31, 'h88);
    imem[64'h108] = enc_d(E_STUR, 3, 0, 8);
    imem[64'h10C] = enc_d(E_LDUR, 5, 0, 8);
    imem[64'h110] = enc_d(E_STUR, 5, 31, 'h90);
    imem[64'h114] = ILLEGAL;
    exp_wq.push_back('{64'h208, 64'd12});
    exp_wq.push_back('{64'h90, 64'd12});
    start_run();
    run_to_halt("ldst_halt", 400);
    check("ldst_writes_left", 64'(exp_wq.size()), 64'h0);
    check("stur_wait_lat", lat(2), 64'd10);
    check("ldur_wait_lat", lat(3), 64'd11);

    // CBZ taken: B from 0x100 back to 0x40, then CBZ X6 (=0) by +3 words.
    clear_all();
    wait_n = 0;
    imem[64'h100] = enc_b(-48);
    imem[64'h40]  = enc_cbz(6, 3);
    imem[64'h44]  = ILLEGAL;
    imem[64'h4C]  = ILLEGAL;
    start_run();
    run_to_halt("cbz0_halt", 100);
    check("b_target", fa(1), 64'h40);
    check("cbz0_target", fa(2), 64'h4C);
    check("b_lat", lat(0), 64'd3);
    check("cbz0_lat", lat(1), 64'd3);

    // CBZ not taken with X6=1.
    clear_all();
    dmem[64'h80] = 64'd1;
    imem[64'h100] = enc_d(E_LDUR, 6, 31, 'h80);
    imem[64'h104] = enc_b(-49);
    imem[64'h40]  = enc_cbz(6, 3);
    imem[64'h44]  = ILLEGAL;
    imem[64'h4C]  = ILLEGAL;
    start_run();
    run_to_halt("cbz1_halt", 100);
    check("cbz1_target", fa(3), 64'h44);
    check("cbz1_lat", lat(2), 64'd3);

    // Asynchronous reset in the middle of a load's MEM wait.
    clear_all();
    wait_n = 3;
    dmem[64'h80] = 64'd5;
    imem[64'h100] = enc_d(E_LDUR, 1, 31, 'h80);
    imem[64'h104] = ILLEGAL;
    start_run();
    begin
      int n = 0;
      while (!(mem_req && mem_addr == 64'h80) && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("mem_phase_seen", mem_addr, 64'h80);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("async_req_drop", {63'h0, mem_req}, 64'h0);
    check("async_pc", pc_out, 64'h100);
    check("async_addr", mem_addr, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_n = 0;
    run_to_halt("after_reset_halt", 100);

`ifdef PERF_COUNTERS_EN
    // Two R-type instructions, zero wait: 8 cycles, 2 retired.
    clear_all();
    wait_n = 0;
    imem[64'h100] = enc_r(E_ADD, 3, 1, 2);
    imem[64'h104] = enc_r(E_SUB, 4, 2, 1);
    imem[64'h108] = ILLEGAL;
    start_run();
    begin
      int n = 0;
      while (perf_retired != 64'd2 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("perf_retired", perf_retired, 64'd2);
      check("perf_cycles", perf_cycles, 64'd8);
    end
    run_to_halt("perf_halt", 100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
